// File: rtl/st_symbol_packer_pkg.sv
// ----------------------------------------------------------------------------
// st_symbol_packer_pkg
// Shared definitions for the symbol packer:
//   clog2        - ceiling log2 for elaboration-time width derivation
//   empty_width  - width of the out_empty field, never less than 1 bit
//   pk_state_t   - packet framing FSM state encoding
// ----------------------------------------------------------------------------
package st_symbol_packer_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-lane packer still needs a 1-bit empty field on the port.
    function automatic int empty_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic {
        WAIT_SOP  = 1'b0,
        IN_PACKET = 1'b1
    } pk_state_t;

endpackage

// File: rtl/st_symbol_packer.sv
// ----------------------------------------------------------------------------
// st_symbol_packer
// Packs a stream of single symbols into beats of OUT_SYMBOLS symbols with
// packet framing. Symbol 0 of a beat sits in the most-significant lane; a
// short final beat is zero-padded and reports the unused lanes on out_empty.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake (readyLatency 0)
//   in_data                  one symbol per transfer
//   in_startofpacket/endof   framing for the input symbol
//   out_valid/out_ready      output handshake (readyLatency 0)
//   out_data                 packed beat
//   out_startofpacket/endof  framing for the output beat
//   out_empty                unused trailing lanes, meaningful with eop
//   protocol_err             sticky framing-violation flag
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !out_valid || out_ready, so a symbol is taken whenever the
// output register is empty or being emptied on the same edge; it never
// depends on in_valid.
// ----------------------------------------------------------------------------
module st_symbol_packer
    import st_symbol_packer_pkg::*;
#(
    parameter int SYMBOL_W    = 8,
    parameter int OUT_SYMBOLS = 4,
    localparam int EMPTY_W    = empty_width(OUT_SYMBOLS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    output logic                            in_ready,
    input  logic                            in_valid,
    input  logic [SYMBOL_W-1:0]             in_data,
    input  logic                            in_startofpacket,
    input  logic                            in_endofpacket,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [SYMBOL_W*OUT_SYMBOLS-1:0] out_data,
    output logic                            out_startofpacket,
    output logic                            out_endofpacket,
    output logic [EMPTY_W-1:0]              out_empty,
    output logic                            protocol_err
);

    localparam int DATA_W    = SYMBOL_W * OUT_SYMBOLS;
    // The last lane never needs storing: the completing symbol goes
    // straight from in_data into the output register.
    localparam int ACC_LANES = (OUT_SYMBOLS > 1) ? OUT_SYMBOLS - 1 : 1;
    localparam logic [EMPTY_W-1:0] LAST = EMPTY_W'(OUT_SYMBOLS - 1);

    pk_state_t          state_q, state_d;
    logic [EMPTY_W-1:0] count_q, count_d;
    logic [EMPTY_W-1:0] base;          // lane the incoming symbol lands in
    logic               acc_sop_q, acc_sop_d;
    logic [SYMBOL_W-1:0] acc_q [ACC_LANES];
    logic               acc_we;
    logic               err_d;
    logic               accept;
    logic               start;         // symbol opens a new packet at lane 0
    logic               keep;          // symbol continues the current packet
    logic               lane0_sop;
    logic               load;
    logic [DATA_W-1:0]  beat_data;
    logic [EMPTY_W-1:0] beat_empty;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Framing FSM, accumulator control and beat assembly.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_sop_d = acc_sop_q;
        err_d     = protocol_err;
        acc_we    = 1'b0;
        load      = 1'b0;
        start     = 1'b0;
        keep      = 1'b0;
        base      = count_q;
        lane0_sop = acc_sop_q;

        if (accept) begin
            case (state_q)
                WAIT_SOP: begin
                    // Symbols outside a packet are dropped.
                    if (in_startofpacket) start = 1'b1;
                    else                  err_d = 1'b1;
                end
                IN_PACKET: begin
                    // A new sop abandons whatever was partially collected.
                    if (in_startofpacket) begin
                        start = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        keep = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (start) base = '0;
        if (base == '0) lane0_sop = start;

        if (start || keep) begin
            if (base == LAST || in_endofpacket) begin
                load      = 1'b1;
                count_d   = '0;
                acc_sop_d = 1'b0;
                state_d   = in_endofpacket ? WAIT_SOP : IN_PACKET;
            end else begin
                acc_we    = 1'b1;
                count_d   = base + EMPTY_W'(1);
                acc_sop_d = lane0_sop;
                state_d   = IN_PACKET;
            end
        end

        beat_data = '0;
        for (int i = 0; i < OUT_SYMBOLS - 1; i++) begin
            if (i < int'(base))
                beat_data[(OUT_SYMBOLS-1-i)*SYMBOL_W +: SYMBOL_W] = acc_q[i];
        end
        for (int i = 0; i < OUT_SYMBOLS; i++) begin
            if (i == int'(base))
                beat_data[(OUT_SYMBOLS-1-i)*SYMBOL_W +: SYMBOL_W] = in_data;
        end

        beat_empty = in_endofpacket ? (LAST - base) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_SOP;
            count_q      <= '0;
            acc_sop_q    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_sop_q    <= acc_sop_d;
            protocol_err <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ACC_LANES; i++) acc_q[i] <= '0;
        end else if (acc_we) begin
            acc_q[base] <= in_data;
        end
    end

    // Output register: reload on a completing symbol (possibly in the same
    // edge as a transfer out), otherwise clear valid once the beat is taken.
    // Payload is only rewritten on load, so it holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
        end else if (load) begin
            out_valid         <= 1'b1;
            out_data          <= beat_data;
            out_startofpacket <= lane0_sop;
            out_endofpacket   <= in_endofpacket;
            out_empty         <= beat_empty;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_st_symbol_packer.sv
// ----------------------------------------------------------------------------
// tb_st_symbol_packer
// Self-checking bench for st_symbol_packer (SYMBOL_W=8, OUT_SYMBOLS=4).
// Directed packets followed by randomized packets, valid gaps, backpressure
// and framing errors, all checked against a packet-level reference model.
// ----------------------------------------------------------------------------
module tb_st_symbol_packer;

    localparam int SW = 8;
    localparam int N  = 4;
    localparam int DW = SW * N;
    localparam int EW = 2;

    logic          clk;
    logic          reset_n;
    logic          in_ready;
    logic          in_valid;
    logic [SW-1:0] in_data;
    logic          in_startofpacket;
    logic          in_endofpacket;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [EW-1:0] out_empty;
    logic          protocol_err;

    st_symbol_packer #(.SYMBOL_W(SW), .OUT_SYMBOLS(N)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .protocol_err      (protocol_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1);
    end

    // ---------------- scoreboard / reference model ----------------
    // Expected beat packed as {data, sop, eop, empty}.
    logic [DW+2+EW-1:0] exp_q[$];
    logic [DW-1:0]      got_q[$];
    logic [SW-1:0]      m_pend[$];
    logic               m_in_pkt;
    logic               m_first;
    logic               m_err;
    int                 total;
    int                 bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_pend.delete();
        m_in_pkt = 1'b0;
        m_first  = 1'b0;
        m_err    = 1'b0;
    endtask

    // Packet-level view: symbols collect in order; a beat is produced when
    // N symbols are collected or the packet ends.
    task automatic model_accept(input logic [SW-1:0] d, input logic s, input logic e);
        logic [DW-1:0] beat;
        if (s) begin
            if (m_in_pkt) m_err = 1'b1;
            m_pend.delete();
            m_first  = 1'b1;
            m_in_pkt = 1'b1;
        end else if (!m_in_pkt) begin
            m_err = 1'b1;
            return;
        end
        m_pend.push_back(d);
        if (m_pend.size() == N || e) begin
            beat = '0;
            for (int i = 0; i < m_pend.size(); i++)
                beat[(N-1-i)*SW +: SW] = m_pend[i];
            exp_q.push_back({beat, m_first, e, e ? EW'(N - m_pend.size()) : EW'(0)});
            m_first = 1'b0;
            m_pend.delete();
            if (e) m_in_pkt = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: drive at negedge, check what the DUT presents, then account
    // for the transfers that the coming rising edge will perform.
    task automatic step(input logic v, input logic [SW-1:0] d, input logic s,
                        input logic e, input logic r, output logic acc);
        logic [DW+2+EW-1:0] x;
        @(negedge clk);
        in_valid         = v;
        in_data          = d;
        in_startofpacket = s;
        in_endofpacket   = e;
        out_ready        = r;
        #1;
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        check_eq("in_ready", in_ready, (exp_q.size() == 0) || r);
        check_eq("protocol_err", protocol_err, m_err);
        if (exp_q.size() != 0) begin
            x = exp_q[0];
            check_eq("out_data", out_data, x[DW+2+EW-1 -: DW]);
            check_eq("out_sop", out_startofpacket, x[EW+1]);
            check_eq("out_eop", out_endofpacket, x[EW]);
            if (x[EW]) check_eq("out_empty", out_empty, x[EW-1:0]);
            if (r) begin
                got_q.push_back(out_data);
                void'(exp_q.pop_front());
            end
        end
        acc = v && in_ready;
        if (acc) model_accept(d, s, e);
    endtask

    task automatic send_sym(input logic [SW-1:0] d, input logic s, input logic e, input logic rnd);
        logic acc;
        logic r;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            r = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            step(1'b1, d, s, e, r, acc);
        end
        check_eq("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n, input logic rnd);
        logic acc;
        logic r;
        for (int k = 0; k < n; k++) begin
            r = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            step(1'b0, 8'($urandom), 1'b0, 1'b0, r, acc);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_out_sop", out_startofpacket, 1'b0);
        check_eq("rst_out_eop", out_endofpacket, 1'b0);
        check_eq("rst_out_empty", out_empty, '0);
        check_eq("rst_protocol_err", protocol_err, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
    endtask

    // Asynchronous assertion between edges, release on a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        total            = 0;
        bad              = 0;
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        out_ready        = 1'b1;
        model_clear();
        #3;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(2, 1'b0);

        // 8-symbol packet -> two full beats
        got_q.delete();
        for (int i = 1; i <= 8; i++)
            send_sym(SW'(i), i == 1, i == 8, 1'b0);
        idle(3, 1'b0);
        check_eq("pkt8_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq("pkt8_beat0", got_q[0], 32'h01020304);
            check_eq("pkt8_beat1", got_q[1], 32'h05060708);
        end

        // 5-symbol packet -> full beat then 1-symbol beat, empty 3
        got_q.delete();
        for (int i = 0; i < 5; i++)
            send_sym(8'hA0 + SW'(i), i == 0, i == 4, 1'b0);
        idle(3, 1'b0);
        check_eq("pkt5_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq("pkt5_beat0", got_q[0], 32'hA0A1A2A3);
            check_eq("pkt5_beat1", got_q[1], 32'hA4000000);
        end

        // Full beat held under 10 cycles of backpressure
        got_q.delete();
        for (int i = 0; i < 4; i++)
            send_sym(8'h10 + SW'(i), i == 0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, acc);
            check_eq("stall_accept", acc, 1'b0);
        end
        for (int i = 4; i < 8; i++)
            send_sym(8'h10 + SW'(i), 1'b0, i == 7, 1'b0);
        idle(3, 1'b0);
        check_eq("stall_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq("stall_beat0", got_q[0], 32'h10111213);
            check_eq("stall_beat1", got_q[1], 32'h14151617);
        end

        // Symbol outside a packet: dropped, sticky error
        got_q.delete();
        send_sym(8'h55, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check_eq("orphan_no_beat", got_q.size(), 0);
        send_sym(8'h66, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b0);
        check_eq("orphan_err_sticky", protocol_err, 1'b1);

        // sop at count 2 restarts the packet
        apply_reset();
        got_q.delete();
        send_sym(8'h30, 1'b1, 1'b0, 1'b0);
        send_sym(8'h31, 1'b0, 1'b0, 1'b0);
        send_sym(8'h40, 1'b1, 1'b0, 1'b0);
        send_sym(8'h41, 1'b0, 1'b0, 1'b0);
        send_sym(8'h42, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        check_eq("resop_beats", got_q.size(), 1);
        if (got_q.size() == 1) check_eq("resop_beat", got_q[0], 32'h40414200);

        // Reset after 3 of 4 symbols drops the partial beat
        apply_reset();
        got_q.delete();
        send_sym(8'h60, 1'b1, 1'b0, 1'b0);
        send_sym(8'h61, 1'b0, 1'b0, 1'b0);
        send_sym(8'h62, 1'b0, 1'b0, 1'b0);
        apply_reset();
        idle(5, 1'b0);
        check_eq("midrst_no_beat", got_q.size(), 0);
        for (int i = 0; i < 4; i++)
            send_sym(8'h70 + SW'(i), i == 0, i == 3, 1'b0);
        idle(3, 1'b0);
        check_eq("midrst_after_beats", got_q.size(), 1);
        if (got_q.size() == 1) check_eq("midrst_after_beat", got_q[0], 32'h70717273);

        // Randomized packets, gaps, backpressure and framing errors
        for (int p = 0; p < 250; p++) begin
            int len;
            logic s;
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                s = (k == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
                send_sym(8'($urandom), s, k == len - 1, 1'b1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
            end
        end
        idle(4, 1'b0);
        check_eq("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/st_symbol_packer.md
ST_SYMBOL_PACKER -- requirements
Module: st_symbol_packer

Interface
REQ-001 SHALL have parameter SYMBOL_W, default 8, meaning bits per symbol.
REQ-002 SHALL have parameter OUT_SYMBOLS, default 4, meaning symbols per output beat (legal range 1..16).
REQ-003 SHALL have derived constant EMPTY_W = max(1, clog2(OUT_SYMBOLS)), meaning out_empty width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_ready  output  1  sink ready, readyLatency 0.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_data  input  SYMBOL_W  one input symbol.
REQ-009 SHALL have port in_startofpacket  input  1  first symbol of packet.
REQ-010 SHALL have port in_endofpacket  input  1  last symbol of packet.
REQ-011 SHALL have port out_ready  input  1  downstream ready, readyLatency 0.
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_data  output  SYMBOL_W*OUT_SYMBOLS  packed beat; symbol 0 in most-significant lane.
REQ-014 SHALL have port out_startofpacket  output  1  beat carries packet's first symbol.
REQ-015 SHALL have port out_endofpacket  output  1  beat carries packet's last symbol.
REQ-016 SHALL have port out_empty  output  EMPTY_W  count of unused least-significant lanes; valid only with out_endofpacket.
REQ-017 SHALL have port protocol_err  output  1  sticky flag for framing violations.

Function
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-019 in_ready SHALL equal !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-020 Accepted symbols SHALL fill an accumulator of OUT_SYMBOLS-1 lanes at index count (0..OUT_SYMBOLS-1), count incrementing per accepted symbol.
REQ-021 A symbol is completing when count == OUT_SYMBOLS-1 or in_endofpacket=1; on accepting it the output register SHALL load {accumulator lanes 0..count-1, in_data, zeros}, out_valid SHALL rise next cycle, count SHALL return to 0.
REQ-022 Latency from completing-symbol acceptance to out_valid SHALL be exactly 1 cycle; throughput one output beat per OUT_SYMBOLS input cycles with no bubbles when out_ready=1.
REQ-023 Simultaneous output transfer and completing-symbol acceptance SHALL reload the output register with out_valid staying 1.
REQ-024 Output transfer with no new completing symbol SHALL clear out_valid next cycle.
REQ-025 out_data, out_startofpacket, out_endofpacket, out_empty SHALL remain stable while out_valid && !out_ready.
REQ-026 out_empty SHALL equal OUT_SYMBOLS-1-count at the eop symbol; 0 on non-eop beats; unused lanes SHALL be zero.
REQ-027 out_startofpacket SHALL be 1 only on the beat whose lane 0 holds the sop symbol.
REQ-028 FSM SHALL have states WAIT_SOP and IN_PACKET; WAIT_SOP -> IN_PACKET on accepted sop without eop; IN_PACKET -> WAIT_SOP on accepted eop; sop&&eop single symbol stays WAIT_SOP and emits a 1-symbol beat with out_empty=OUT_SYMBOLS-1.
REQ-029 In WAIT_SOP, accepted symbols without sop SHALL be discarded (no output) and SHALL set protocol_err.
REQ-030 In IN_PACKET, accepted sop SHALL discard the partial accumulator, set protocol_err, and start a new packet with that symbol at lane 0.
REQ-031 OUT_SYMBOLS=1 SHALL behave as a 1-stage registered pass-through with out_empty always 0.

Reset
REQ-032 reset_n low SHALL asynchronously force out_valid=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, out_data=0, count=0, state=WAIT_SOP, protocol_err=0.
REQ-033 Reset mid-packet SHALL drop all partial and held data; no beat SHALL be emitted for it after release.
REQ-034 in_ready SHALL be 1 during and after reset (out_valid=0).

Structure
REQ-035 A shared package SHALL hold the clog2 function, the FSM state enumeration, and EMPTY_W derivation.
REQ-036 Single module, no sub-modules.

Verification
REQ-037 SYMBOL_W=8, OUT_SYMBOLS=4, 8-symbol packet 0x01..0x08, out_ready=1 -> beats 0x01020304 (sop, empty 0) then 0x05060708 (eop, empty 0), each 1 cycle after 4th symbol.
REQ-038 5-symbol packet 0xA0..0xA4 -> beats 0xA0A1A2A3 (sop) then 0xA4000000 (eop, empty 3).
REQ-039 out_ready=0 for 10 cycles with full beat held -> in_ready=0, out_data stable, no symbol lost; release -> stream resumes in order.
REQ-040 Symbol 0x55 without sop in WAIT_SOP -> no output, protocol_err=1 and stays 1 until reset.
REQ-041 sop at count=2 inside packet -> partial discarded, protocol_err=1, new beat lane 0 holds the new sop symbol.
REQ-042 reset_n pulsed low after 3 of 4 symbols -> all outputs 0 immediately, no beat emitted after release.
